// File: rtl/aoi_eval_scheduler_pkg.sv
// Shared types and helpers for the round-robin OR-AND evaluation scheduler.
package aoi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_OP_W    = 1;
  localparam int unsigned MAX_REQ     = 8;

  // First valid index after 'last', wrapping modulo n; 0 when nothing is valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (!found && valid[idx[2:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/aoi_eval_scheduler_if.sv
// Request/response bundle between the operand sources, the scheduler and the result consumer.
interface aoi_sched_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned OP_W    = 1
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0] req_c;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic [OP_W-1:0]         rsp_data;
  logic [IDW-1:0]          rsp_id;
  logic                    rsp_ready;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/aoi_eval_scheduler_cells.sv
// Single-bit OR and AND cells forming the shared evaluation datapath.
module or_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module and_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/aoi_eval_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches from last_gnt+1 with wrap-around.
module rr_arbiter
  import aoi_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     last_gnt,
  output logic [IDW-1:0]     gnt,
  output logic               any_req
);

  assign gnt     = IDW'(rr_pick(MAX_REQ'(req_valid), 32'(last_gnt), NUM_REQ));
  assign any_req = |req_valid;

endmodule

// File: rtl/aoi_eval_scheduler.sv
// Round-robin scheduler sharing one bitwise (a|b)&c cell between NUM_REQ requesters.
// Define AOI_SCHED_CNT_EN to add the saturating done_cnt completion counter.
module aoi_eval_scheduler
  import aoi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned OP_W    = DEF_OP_W
) (
  input  logic        clk,
  input  logic        rst_n,
  aoi_sched_if.slave  bus,
`ifdef AOI_SCHED_CNT_EN
  output logic [7:0]  done_cnt,
`endif
  output logic        busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_gnt, gnt, gnt_q;
  logic               any_req;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready;
  logic               rsp_valid;
  logic [OP_W-1:0]    sel_a, sel_b, sel_c;
  logic [OP_W-1:0]    op_a, op_b, op_c;
  logic [OP_W-1:0]    or_y, eval_y;
  logic [OP_W-1:0]    rsp_data_q;
  logic [IDW-1:0]     rsp_id_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .last_gnt  (last_gnt),
    .gnt       (gnt),
    .any_req   (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_a = bus.req_a[i*OP_W +: OP_W];
        sel_b = bus.req_b[i*OP_W +: OP_W];
        sel_c = bus.req_c[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d        = EVAL;
        accept         = 1'b1;
        req_ready[gnt] = 1'b1;
      end
      EVAL: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      gnt_q      <= '0;
      last_gnt   <= IDW'(NUM_REQ - 1);
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      if (accept) begin
        op_a     <= sel_a;
        op_b     <= sel_b;
        op_c     <= sel_c;
        gnt_q    <= gnt;
        last_gnt <= gnt;
      end
      if (state_q == EVAL) begin
        rsp_data_q <= eval_y;
        rsp_id_q   <= gnt_q;
      end
    end
  end

  for (genvar g = 0; g < OP_W; g++) begin : g_cell
    or_cell  u_or  (.a(op_a[g]), .b(op_b[g]), .y(or_y[g]));
    and_cell u_and (.a(or_y[g]), .b(op_c[g]), .y(eval_y[g]));
  end

`ifdef AOI_SCHED_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done_cnt <= '0;
    else if (rsp_valid && bus.rsp_ready && done_cnt != '1)
      done_cnt <= done_cnt + 8'd1;
  end
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);

endmodule
